// File: rtl/game_pkg.sv
// Shared game constants: state encodings, key/switch box origins, box size,
// and the near-box test used by the interaction logic.
package game_pkg;

    localparam logic [3:0] ST_TITLE  = 4'd0;
    localparam logic [3:0] ST_STAGE1 = 4'd1;
    localparam logic [3:0] ST_STAGE2 = 4'd2;
    localparam logic [3:0] ST_STAGE3 = 4'd3;
    localparam logic [3:0] ST_CLEAR1 = 4'd4;
    localparam logic [3:0] ST_CLEAR2 = 4'd5;
    localparam logic [3:0] ST_CLEAR3 = 4'd6;
    localparam logic [3:0] ST_WIN    = 4'd7;
    localparam logic [3:0] ST_FAIL   = 4'd8;

    localparam logic [9:0] BOX_SIZE = 10'd10;

    localparam logic [9:0] KEY0_X = 10'd70;
    localparam logic [9:0] KEY0_Y = 10'd40;
    localparam logic [9:0] KEY1_X = 10'd235;
    localparam logic [9:0] KEY1_Y = 10'd40;
    localparam logic [9:0] KEY2_X = 10'd215;
    localparam logic [9:0] KEY2_Y = 10'd220;
    localparam logic [9:0] SW_X   = 10'd70;
    localparam logic [9:0] SW_Y   = 10'd220;

    function automatic logic [9:0] key_x(input logic [1:0] idx);
        case (idx)
            2'd0:    return KEY0_X;
            2'd1:    return KEY1_X;
            2'd2:    return KEY2_X;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] key_y(input logic [1:0] idx);
        case (idx)
            2'd0:    return KEY0_Y;
            2'd1:    return KEY1_Y;
            2'd2:    return KEY2_Y;
            default: return 10'd0;
        endcase
    endfunction

    // Low bound clamps at 0 so boxes near the screen edge stay reachable.
    function automatic logic near_box(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] ox, input logic [9:0] oy,
                                      input logic [9:0] margin);
        logic [9:0] lo_x;
        logic [9:0] lo_y;
        lo_x = (ox >= margin) ? ox - margin : 10'd0;
        lo_y = (oy >= margin) ? oy - margin : 10'd0;
        return (px >= lo_x) && (px < ox + BOX_SIZE + margin) &&
               (py >= lo_y) && (py < oy + BOX_SIZE + margin);
    endfunction

endpackage

// File: rtl/light_timer.sv
// Loadable 8-bit frame down-counter; expire pulses for one cycle after the
// count steps from 1 to 0. Clear has priority over load, load over stepping.
module light_timer #(
    parameter logic [7:0] LOAD_VAL = 8'd180
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic load,
    input  logic clear,
    output logic expire
);

    logic [7:0] count_q, count_d;
    logic       expire_q, expire_d;

    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
        if (clear) begin
            count_d = 8'd0;
        end else if (load) begin
            count_d = LOAD_VAL;
        end else if (frame_tick && count_q != 8'd0) begin
            count_d  = count_q - 8'd1;
            expire_d = (count_q == 8'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 8'd0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/key_light_ctrl.sv
// Key progress and stage-2 lighting control. Define LIGHT_TIMER_EN for a
// one-shot timed light; otherwise the switch toggles the light.
module key_light_ctrl
    import game_pkg::*;
#(
    parameter int LIGHT_FRAMES = 180,
    parameter int MARGIN       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    input  logic       interact,
    input  logic       frame_tick,
    output logic [1:0] key_find,
    output logic       isDark,
    output logic       pickup,
    output logic       stage_clear
);

    localparam logic [9:0] MARGIN_V = 10'(MARGIN);

    logic [3:0] prev_state_q;
    logic [1:0] key_find_q, key_find_d;
    logic       is_dark_q, is_dark_d;
    logic       pickup_q, pickup_d;
    logic       stage_clear_q, stage_clear_d;

    logic       state_chg, active, in_stage2;
    logic       near_key, near_sw, key_ok, sw_hit;
    logic [9:0] px, py;

`ifdef LIGHT_TIMER_EN
    logic timer_load, timer_clear, timer_expire;

    light_timer #(
        .LOAD_VAL(8'(LIGHT_FRAMES))
    ) u_light_timer (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .load      (timer_load),
        .clear     (timer_clear),
        .expire    (timer_expire)
    );
`else
    logic unused_cfg;
    assign unused_cfg = frame_tick | (LIGHT_FRAMES == 0);
`endif

    assign px        = {1'b0, player_x};
    assign py        = {1'b0, player_y};
    assign state_chg = (state != prev_state_q);
    assign in_stage2 = (state == ST_STAGE2);
    assign active    = (state == ST_STAGE1) || in_stage2 || (state == ST_STAGE3);
    assign near_key  = near_box(px, py, key_x(key_find_q), key_y(key_find_q), MARGIN_V);
    assign near_sw   = near_box(px, py, SW_X, SW_Y, MARGIN_V);

    // Key0 in stage 2 needs the light on; later keys can be found in the dark.
    assign key_ok = active && interact && !state_chg && (key_find_q != 2'd3) &&
                    near_key && (!in_stage2 || !is_dark_q || key_find_q != 2'd0);
    assign sw_hit = in_stage2 && interact && !state_chg && !key_ok && near_sw;

    always_comb begin
        key_find_d    = key_find_q;
        is_dark_d     = is_dark_q;
        pickup_d      = 1'b0;
        stage_clear_d = 1'b0;
`ifdef LIGHT_TIMER_EN
        timer_load    = 1'b0;
        timer_clear   = 1'b0;
`endif
        if (state_chg) begin
            key_find_d = 2'd0;
            is_dark_d  = in_stage2;
`ifdef LIGHT_TIMER_EN
            timer_clear = 1'b1;
`endif
        end else begin
            if (key_ok) begin
                key_find_d    = key_find_q + 2'd1;
                pickup_d      = 1'b1;
                stage_clear_d = (key_find_q == 2'd2);
            end
            if (!in_stage2) begin
                is_dark_d = 1'b0;
            end else if (sw_hit) begin
`ifdef LIGHT_TIMER_EN
                is_dark_d  = 1'b0;
                timer_load = 1'b1;
`else
                is_dark_d  = !is_dark_q;
`endif
            end
`ifdef LIGHT_TIMER_EN
            else if (timer_expire) begin
                is_dark_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state_q  <= ST_TITLE;
            key_find_q    <= 2'd0;
            is_dark_q     <= 1'b0;
            pickup_q      <= 1'b0;
            stage_clear_q <= 1'b0;
        end else begin
            prev_state_q  <= state;
            key_find_q    <= key_find_d;
            is_dark_q     <= is_dark_d;
            pickup_q      <= pickup_d;
            stage_clear_q <= stage_clear_d;
        end
    end

    assign key_find    = key_find_q;
    assign isDark      = is_dark_q;
    assign pickup      = pickup_q;
    assign stage_clear = stage_clear_q;

endmodule

// File: doc/key_light_ctrl.md
# key_light_ctrl

Sequential game-logic stage that produces the `key_find` progress count and the `isDark` lighting flag consumed by the object renderer. It sits between the game-state FSM and player-movement logic upstream and the renderer downstream. It detects player interaction at each key and at the stage-2 light switch, and advances key progress in order. It also runs the stage-2 light timer and flags stage completion.

## Interface
- `LIGHT_FRAMES`, default 180: frames the light stays on after the switch is pressed (3 s at 60 Hz).
- `MARGIN`, default 8: pickup tolerance in half-resolution pixels around each 10×10 target box.
- `clk` input, 1 bit: system clock. One clock domain.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `state` input, 4 bits: game state, using the shared encoding (TITLE=0 … FAIL=8).
- `player_x` input, 9 bits: player centre X in 320×240 coordinates.
- `player_y` input, 9 bits: player centre Y in 320×240 coordinates.
- `interact` input, 1 bit: one-cycle pulse from the debounced action button.
- `frame_tick` input, 1 bit: one-cycle pulse per VGA frame.
- `key_find` output, 2 bits: index of the next key to find; 3 means all keys are found.
- `isDark` output, 1 bit: room is dark. Only ever asserted in STAGE2.
- `pickup` output, 1 bit: one-cycle pulse on each successful key pickup, for the sound/LED hooks.
- `stage_clear` output, 1 bit: one-cycle pulse when `key_find` goes from 2 to 3.

## Operation
- Target boxes, each 10×10 with origin at the top-left:
  - key0 at (70,40), key1 at (235,40), key2 at (215,220).
  - Light switch at (70,220), active in STAGE2 only.
- "Near" a box means: `ox-MARGIN ≤ player_x < ox+10+MARGIN`, and the same test in Y.
  - Use unsigned 10-bit arithmetic.
  - A low bound that would go below 0 clamps to 0.
- The block tracks the previous `state` in a register (`prev_state`).
- When `state` differs from `prev_state`:
  - `key_find` is set to 0 and the light timer is cleared.
  - `isDark` becomes 1 if the new state is STAGE2, otherwise 0.
  - A state change overrides any `interact` in the same cycle.
- Active states are STAGE1, STAGE2 and STAGE3. In any other state, `interact` is ignored and `isDark` is 0.
- Key pickup, on `interact`:
  - A pickup happens when `key_find<3`, the player is near the box of key[`key_find`], and (`state`≠STAGE2 or `isDark`=0 or `key_find`≠0).
  - On pickup, `key_find` increments and `pickup` pulses.
- Keys must be collected in order. Being near a later key does nothing.
- `key_find` saturates at 3. Further `interact` pulses have no effect.
- Light switch, in STAGE2, on `interact` when the player is near the switch and no key pickup fires in that cycle: `isDark` goes to 0 and the timer loads `LIGHT_FRAMES`.
- Priority: key pickup before switch. Only one action per `interact`.

## Timing
- All outputs are registered.
- Reset values: `key_find`=0, `isDark`=0, `pickup`=0, `stage_clear`=0, timer=0, `prev_state`=TITLE.
- `interact` sampled high at edge N: `key_find`, `pickup` and `isDark` update at edge N+1.
- `stage_clear` pulses in the same cycle that `key_find` becomes 3.
- The light timer decrements on `frame_tick` while it is nonzero.
  - The tick that moves the timer from 1 to 0 sets `isDark`=1 on the next edge.
- `interact` and the final `frame_tick` in the same cycle at the switch: the reload wins and the light stays on.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Configuration
- `LIGHT_TIMER_EN` defined:
  - The light behaves as above: one-shot on, auto-off after `LIGHT_FRAMES` frames.
- `LIGHT_TIMER_EN` undefined:
  - The timer and its sub-module are not built.
  - A switch press toggles `isDark`. `frame_tick` is unused.

## Structure
- Shared package `game_pkg` holds:
  - the state encodings (TITLE … FAIL);
  - the key and switch box origins;
  - the box size (10).
- Sub-module `light_timer`:
  - a loadable down-counter stepped by `frame_tick`, 8 bits wide (covers `LIGHT_FRAMES`≤255);
  - inputs `load` and `clear`; output `expire`, a one-cycle pulse when the count reaches 0.
- The near-box comparison is a function in `game_pkg`.

## Test plan
- STAGE1: player at (75,45), `interact` → next cycle `key_find`=1 and `pickup`=1 for exactly one cycle.
- STAGE1, `key_find`=0: player at (240,45), `interact` → `key_find` stays 0 and there is no pickup.
- Enter STAGE2:
  - `isDark`=1; player at (75,45) with `interact` → `key_find` stays 0.
  - Then player at (75,225) with `interact` → `isDark`=0; then `interact` at (75,45) → `key_find`=1.
- STAGE2 with `LIGHT_TIMER_EN`: press the switch, issue 180 `frame_tick` → `isDark` returns to 1 one cycle after the 180th tick. At 179 ticks it is still 0.
- STAGE3: collect the keys in order at (75,45), (240,45) and (220,225) → `key_find`=3 with a single `stage_clear` pulse. A fourth `interact` → no change.
- Mid-stage (`key_find`=2):
  - `state` changes to STAGE3 in the same cycle as a valid `interact` → `key_find`=0.
  - Async `rst` pulse between clock edges → all outputs 0 immediately.
